// File: rtl/zlib_stored.sv
// ----------------------------------------------------------------------------
// zlib_stored
//   Wraps the filtered RGBA8 scanline byte stream (one filter byte plus 4*w
//   pixel bytes per row) into a zlib stream. The stream is the zlib header
//   78 01, then deflate stored blocks of at most BLK_MAX payload bytes, then
//   the Adler-32 of the payload. The output feeds the crc32 IDAT inputs and
//   the file writer.
//   Words on both sides are byte-packed, MSB-first. num = valid bytes - 1,
//   and valid bytes are left-aligned in the word.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   w_i, h_i           picture width (pixels) and height (rows), sampled on start_i
//   start_i            one-cycle pulse; starts a stream when idle
//   val_i/rdy_o        input handshake; a word is taken when val_i && rdy_o
//   dat_i, num_i       input bytes and (valid bytes - 1)
//   lst_i              marks the final input word (length check only)
//   val_o, dat_o       output word valid and bytes; the sink never stalls
//   num_o, lst_o       output (valid bytes - 1) and final-word marker
//   done_o             one-cycle pulse together with lst_o
//   err_o              sticky length-mismatch flag
//
// Configuration
//   ZLIB_STORED_LEN_CHK_EN  when defined, err_o flags input streams whose
//                           lst_i disagrees with the byte count derived from
//                           w*h. When undefined, err_o is 0 and lst_i is unused.
// ----------------------------------------------------------------------------
module zlib_stored #(
  parameter int BLK_MAX     = 65532,
  parameter int DATA_WD     = 32,
  parameter int SIZE_PIC_WD = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [SIZE_PIC_WD-1:0] w_i,
  input  logic [SIZE_PIC_WD-1:0] h_i,
  input  logic                   start_i,
  input  logic                   val_i,
  input  logic [DATA_WD-1:0]     dat_i,
  input  logic [1:0]             num_i,
  input  logic                   lst_i,
  output logic                   rdy_o,
  output logic                   val_o,
  output logic [DATA_WD-1:0]     dat_o,
  output logic [1:0]             num_o,
  output logic                   lst_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [19:0] ADLER_MOD   = 20'd65521;
  localparam logic [15:0] BLK_LEN_MAX = 16'(BLK_MAX);

  typedef enum logic [2:0] {IDLE, ZHDR, BHDR0, BHDR1, DATA, ADLER, FLUSH} state_t;

  state_t                 state_q;
  logic [SIZE_PIC_WD-1:0] rem_q;
  logic [15:0]            blk_q;
  logic [7:0]             len_hi_q;
  logic [63:0]            buf_q;
  logic [1:0]             occ_q;
  logic [15:0]            s1_q;
  logic [15:0]            s2_q;

  logic                   acc;
  logic [2:0]             num_raw;
  logic [2:0]             n_dat;
  logic [31:0]            dat_m;
  logic [SIZE_PIC_WD-1:0] rem_n;
  logic [15:0]            blk_n;
  logic                   bfinal;
  logic [15:0]            blk_len;
  logic [SIZE_PIC_WD-1:0] t_calc;
  logic [31:0]            push_w;
  logic [2:0]             push_n;
  logic [63:0]            comb_buf;
  logic [2:0]             tot;
  logic [19:0]            cum [4];
  logic [19:0]            s2_sum;
  logic [15:0]            s1_n;
  logic [15:0]            s2_n;

  assign rdy_o   = (state_q == DATA);
  assign acc     = val_i && rdy_o;
  assign num_raw = {1'b0, num_i} + 3'd1;
  // Framing follows the byte count from w*h. A word that carries more bytes
  // than the block still needs is clipped to the remaining block length.
  assign n_dat   = ({13'd0, num_raw} > blk_q) ? blk_q[2:0] : num_raw;
  assign rem_n   = rem_q - SIZE_PIC_WD'(n_dat);
  assign blk_n   = blk_q - {13'd0, n_dat};
  assign bfinal  = (rem_q <= SIZE_PIC_WD'(BLK_MAX));
  assign blk_len = bfinal ? rem_q[15:0] : BLK_LEN_MAX;
  assign t_calc  = h_i * ((w_i << 2) + SIZE_PIC_WD'(1));

  // Zero the input bytes that are not counted, so that they neither reach
  // the byte buffer nor contribute to the checksum.
  always_comb begin
    dat_m = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n_dat) dat_m[31-8*k -: 8] = dat_i[31-8*k -: 8];
    end
  end

  // Adler-32 update for up to four bytes in one cycle. cum[k] is s1 after
  // byte k. s2 adds the running s1 once for each byte that is actually
  // present, so a short final word does not add s1 for the missing bytes.
  always_comb begin
    cum[0] = {4'd0, s1_q} + {12'd0, dat_m[31:24]};
    cum[1] = cum[0] + {12'd0, dat_m[23:16]};
    cum[2] = cum[1] + {12'd0, dat_m[15:8]};
    cum[3] = cum[2] + {12'd0, dat_m[7:0]};
    s1_n   = 16'((cum[3] >= ADLER_MOD) ? cum[3] - ADLER_MOD : cum[3]);
    s2_sum = {4'd0, s2_q};
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n_dat) s2_sum = s2_sum + cum[k];
    end
    // The sum stays below 6*65521, so five conditional subtracts give the
    // exact remainder.
    for (int r = 0; r < 5; r++) begin
      if (s2_sum >= ADLER_MOD) s2_sum = s2_sum - ADLER_MOD;
    end
    s2_n = 16'(s2_sum);
  end

  // Select this cycle's push into the byte buffer and append it behind the
  // bytes already held. Bytes beyond the occupancy are always zero, so an OR
  // merges the push with the held bytes.
  always_comb begin
    push_w = '0;
    push_n = 3'd0;
    case (state_q)
      ZHDR: begin
        push_w = 32'h7801_0000;
        push_n = 3'd2;
      end
      BHDR0: begin
        push_w = {7'd0, bfinal, blk_len[7:0], blk_len[15:8], ~blk_len[7:0]};
        push_n = 3'd4;
      end
      BHDR1: begin
        push_w = {~len_hi_q, 24'd0};
        push_n = 3'd1;
      end
      DATA: begin
        if (acc) begin
          push_w = dat_m;
          push_n = n_dat;
        end
      end
      ADLER: begin
        push_w = {s2_q, s1_q};
        push_n = 3'd4;
      end
      default: ;
    endcase
    comb_buf = buf_q | ({push_w, 32'd0} >> {occ_q, 3'b000});
    tot      = {1'b0, occ_q} + push_n;
  end

  // Main sequencer. Whenever four bytes are available they go straight to
  // the output registers. The held occupancy is at most 3 and a push adds at
  // most 4, so the 8-byte buffer never has to stall the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      blk_q    <= '0;
      len_hi_q <= '0;
      buf_q    <= '0;
      occ_q    <= '0;
      s1_q     <= 16'd1;
      s2_q     <= 16'd0;
      val_o    <= 1'b0;
      dat_o    <= '0;
      num_o    <= 2'd0;
      lst_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      val_o  <= 1'b0;
      dat_o  <= '0;
      num_o  <= 2'd0;
      lst_o  <= 1'b0;
      done_o <= 1'b0;

      if (tot >= 3'd4) begin
        val_o <= 1'b1;
        dat_o <= comb_buf[63:32];
        num_o <= 2'd3;
        buf_q <= {comb_buf[31:0], 32'd0};
        occ_q <= 2'(tot - 3'd4);
        // The Adler bytes fill the word exactly, so this word ends the stream.
        if (state_q == ADLER && tot == 3'd4) begin
          lst_o  <= 1'b1;
          done_o <= 1'b1;
        end
      end else begin
        buf_q <= comb_buf;
        occ_q <= tot[1:0];
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_q   <= t_calc;
            s1_q    <= 16'd1;
            s2_q    <= 16'd0;
            state_q <= ZHDR;
          end
        end
        ZHDR:  state_q <= BHDR0;
        BHDR0: begin
          blk_q    <= blk_len;
          len_hi_q <= blk_len[15:8];
          state_q  <= BHDR1;
        end
        // An empty picture has no payload, so the FSM skips DATA and
        // rdy_o never goes high.
        BHDR1: state_q <= (rem_q == '0) ? ADLER : DATA;
        DATA: begin
          if (acc) begin
            rem_q <= rem_n;
            blk_q <= blk_n;
            s1_q  <= s1_n;
            s2_q  <= s2_n;
            if (rem_n == '0)        state_q <= ADLER;
            else if (blk_n == 16'd0) state_q <= BHDR0;
          end
        end
        ADLER: state_q <= FLUSH;
        // Emit the 1..3 trailing bytes. If the Adler word already ended the
        // stream, the buffer is empty and nothing is emitted here.
        FLUSH: begin
          if (occ_q != 2'd0) begin
            val_o  <= 1'b1;
            dat_o  <= comb_buf[63:32];
            num_o  <= occ_q - 2'd1;
            lst_o  <= 1'b1;
            done_o <= 1'b1;
          end
          buf_q   <= '0;
          occ_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ZLIB_STORED_LEN_CHK_EN
  logic err_q;

  // Sticky mismatch between the source's lst_i and the length from w*h.
  // It is cleared only when a new stream starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      err_q <= 1'b0;
    end else if (acc) begin
      if (lst_i && rem_q != SIZE_PIC_WD'(num_raw)) err_q <= 1'b1;
      if (rem_n == '0 && !lst_i)                  err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_lst;

  assign unused_lst = lst_i;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_zlib_stored.sv
`timescale 1ns/1ps
module tb_zlib_stored;

  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] w_i = '0;
  logic [31:0] h_i = '0;
  logic        start_i = 1'b0;
  logic        val_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic [1:0]  num_i = '0;
  logic        lst_i = 1'b0;
  logic        rdy_o, val_o, lst_o, done_o, err_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;

  always #5 clk = ~clk;

  zlib_stored #(.BLK_MAX(BLK), .DATA_WD(32), .SIZE_PIC_WD(32)) dut (
    .clk(clk), .rstn(rstn), .w_i(w_i), .h_i(h_i), .start_i(start_i),
    .val_i(val_i), .dat_i(dat_i), .num_i(num_i), .lst_i(lst_i),
    .rdy_o(rdy_o), .val_o(val_o), .dat_o(dat_o), .num_o(num_o),
    .lst_o(lst_o), .done_o(done_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;
  int cur_t = 0;
  bit rdy_seen = 0;
  bit done_seen = 0;

  logic [7:0]  src_bytes[$];
  logic [31:0] got_dat[$];
  logic [1:0]  got_num[$];
  logic        got_lst[$];
  logic        got_done[$];
  logic [31:0] exp_dat[$];
  logic [1:0]  exp_num[$];
  logic        exp_lst[$];

  typedef struct {
    int          w;
    int          h;
    logic [39:0] in_bytes;
    int          exp_cnt;
    logic [31:0] exp_w[4];
    logic [1:0]  last_num;
  } vec_t;

  // Collect every output word away from the active edge.
  always @(negedge clk) begin
    if (val_o) begin
      got_dat.push_back(dat_o);
      got_num.push_back(num_o);
      got_lst.push_back(lst_o);
      got_done.push_back(done_o);
    end
    if (rdy_o) rdy_seen = 1'b1;
    if (done_o) done_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] num_mask(input logic [1:0] n);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    return m << (8 * (3 - int'(n)));
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference zlib stream built byte by byte from the stream rules.
  task automatic build_model(input int t);
    logic [7:0]  s[$];
    logic [31:0] wd;
    int rem, pos, l, a, b, nb;
    exp_dat.delete(); exp_num.delete(); exp_lst.delete();
    s.push_back(8'h78); s.push_back(8'h01);
    rem = t; pos = 0;
    do begin
      l = (rem > BLK) ? BLK : rem;
      s.push_back((l == rem) ? 8'h01 : 8'h00);
      s.push_back(8'(l)); s.push_back(8'(l >> 8));
      s.push_back(8'(~l)); s.push_back(8'((~l) >> 8));
      for (int i = 0; i < l; i++) s.push_back(src_bytes[pos + i]);
      pos += l; rem -= l;
    end while (rem > 0);
    a = 1; b = 0;
    for (int i = 0; i < t; i++) begin
      a = (a + int'(src_bytes[i])) % 65521;
      b = (b + a) % 65521;
    end
    s.push_back(8'(b >> 8)); s.push_back(8'(b)); s.push_back(8'(a >> 8)); s.push_back(8'(a));
    for (int i = 0; i < s.size(); i += 4) begin
      nb = (s.size() - i >= 4) ? 4 : s.size() - i;
      wd = '0;
      for (int k = 0; k < nb; k++) wd[31-8*k -: 8] = s[i + k];
      exp_dat.push_back(wd);
      exp_num.push_back(2'(nb - 1));
      exp_lst.push_back(i + 4 >= s.size());
    end
  endtask

  task automatic fill_random(input int t);
    src_bytes.delete();
    for (int i = 0; i < t; i++) src_bytes.push_back(8'($urandom_range(255)));
  endtask

  // Start a stream and feed src_bytes with the rdy_o handshake.
  task automatic applyStimulus(input string name, input int w, input int h, input int gap_pct,
                               input int stall_at, input bit repulse, input bit lst_first);
    int idx, nb, cyc, stall_left;
    bit acc, pulsed, stalled;
    logic [31:0] wd;
    @(posedge clk); #1;
    cur_t = h * (4 * w + 1);
    got_dat.delete(); got_num.delete(); got_lst.delete(); got_done.delete();
    rdy_seen = 0; done_seen = 0;
    w_i = 32'(w); h_i = 32'(h); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    idx = 0; cyc = 0; pulsed = 0; stalled = 0; stall_left = 0;
    while (idx < cur_t && cyc < 5000) begin
      nb = (cur_t - idx >= 4) ? 4 : cur_t - idx;
      if (!stalled && stall_at >= 0 && idx >= stall_at) begin
        stalled = 1; stall_left = 5;
      end
      if (stall_left > 0) begin
        val_i = 1'b0; stall_left--;
      end else if ($urandom_range(99) < gap_pct) begin
        val_i = 1'b0;
      end else begin
        wd = '0;
        for (int k = 0; k < nb; k++) wd[31-8*k -: 8] = src_bytes[idx + k];
        val_i = 1'b1; dat_i = wd; num_i = 2'(nb - 1);
        lst_i = lst_first ? (idx == 0) : (idx + nb == cur_t);
      end
      if (repulse && !pulsed && rdy_o) begin
        start_i = 1'b1; pulsed = 1;
      end
      @(negedge clk);
      acc = val_i && rdy_o;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (acc) idx += nb;
      cyc++;
    end
    val_i = 1'b0; lst_i = 1'b0; dat_i = '0; num_i = '0;
    cyc = 0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("[TB] FAIL %s_done: done_o got 0, expected 1 within budget", name);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compare the collected words with the reference model.
  task automatic checkOutput(input string name);
    logic [31:0] m;
    build_model(cur_t);
    check_val({name, "_wordcount"}, 64'(got_dat.size()), 64'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      m = num_mask(exp_num[i]);
      checks++;
      if ((got_dat[i] & m) !== exp_dat[i] || got_num[i] !== exp_num[i] ||
          got_lst[i] !== exp_lst[i] || got_done[i] !== exp_lst[i]) begin
        errors++;
        $display("[TB] FAIL %s_w%0d: got dat=%h num=%0d lst=%0b done=%0b, expected dat=%h num=%0d lst=%0b done=%0b",
                 name, i, got_dat[i] & m, got_num[i], got_lst[i], got_done[i],
                 exp_dat[i], exp_num[i], exp_lst[i], exp_lst[i]);
      end
    end
  endtask

  initial begin
    vec_t        vecs[2];
    logic [31:0] adler_a, adler_b;
    logic [31:0] m;
    logic        exp_err;
    int          t, cyc, w, h, sa;

    vecs[0].w = 1; vecs[0].h = 1; vecs[0].in_bytes = 40'h00_1122_3344; vecs[0].exp_cnt = 4;
    vecs[0].exp_w[0] = 32'h7801_0105; vecs[0].exp_w[1] = 32'h00FA_FF00;
    vecs[0].exp_w[2] = 32'h1122_3344; vecs[0].exp_w[3] = 32'h0159_00AB; vecs[0].last_num = 2'd3;
    vecs[1].w = 0; vecs[1].h = 0; vecs[1].in_bytes = 40'h0; vecs[1].exp_cnt = 3;
    vecs[1].exp_w[0] = 32'h7801_0100; vecs[1].exp_w[1] = 32'h00FF_FF00;
    vecs[1].exp_w[2] = 32'h0000_0100; vecs[1].exp_w[3] = 32'h0; vecs[1].last_num = 2'd2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {25'd0, val_o, dat_o, num_o, lst_o, done_o, rdy_o, err_o}, 64'd0);
    rstn = 1'b1;

    // Directed vectors with explicit expected words.
    for (int v = 0; v < 2; v++) begin
      t = vecs[v].h * (4 * vecs[v].w + 1);
      src_bytes.delete();
      for (int i = 0; i < t; i++) src_bytes.push_back(vecs[v].in_bytes[39-8*i -: 8]);
      applyStimulus($sformatf("vec%0d", v), vecs[v].w, vecs[v].h, 0, -1, 0, 0);
      check_val($sformatf("vec%0d_count", v), 64'(got_dat.size()), 64'(vecs[v].exp_cnt));
      for (int i = 0; i < vecs[v].exp_cnt && i < got_dat.size(); i++) begin
        m = num_mask((i == vecs[v].exp_cnt - 1) ? vecs[v].last_num : 2'd3);
        check_val($sformatf("vec%0d_w%0d", v, i),
                  {got_dat[i] & m, 28'd0, got_num[i], got_lst[i], got_done[i]},
                  {vecs[v].exp_w[i], 28'd0,
                   (i == vecs[v].exp_cnt - 1) ? vecs[v].last_num : 2'd3,
                   i == vecs[v].exp_cnt - 1, i == vecs[v].exp_cnt - 1});
      end
      check_val($sformatf("vec%0d_rdy_seen", v), 64'(rdy_seen), 64'(t > 0));
    end

    // Two blocks with the 8-byte block limit.
    fill_random(15);
    applyStimulus("blk8", 1, 3, 0, -1, 0, 0);
    checkOutput("blk8");
    if (got_dat.size() >= 8) begin
      check_val("blk8_hdr1a", 64'(got_dat[0]), 64'h7801_0008);
      check_val("blk8_hdr1b", 64'(got_dat[1][31:8]), 64'h00F7FF);
      check_val("blk8_hdr2a", 64'(got_dat[3][7:0]), 64'h01);
      check_val("blk8_hdr2b", 64'(got_dat[4]), 64'h0700_F8FF);
      check_val("blk8_last", {62'd0, got_num[7]}, 64'd2);
    end else begin
      check_val("blk8_size", 64'(got_dat.size()), 64'd8);
    end

    // A 5-cycle stall mid-DATA must leave the stream and Adler unchanged.
    fill_random(18);
    applyStimulus("nogap", 2, 2, 0, -1, 0, 0);
    checkOutput("nogap");
    adler_a = (got_dat.size() > 0) ? got_dat[got_dat.size() - 1] : 32'hDEAD_BEEF;
    applyStimulus("stall", 2, 2, 0, 4, 0, 0);
    checkOutput("stall");
    adler_b = (got_dat.size() > 0) ? got_dat[got_dat.size() - 1] : 32'hBAD0_BAD0;
    check_val("stall_adler_same", 64'(adler_b), 64'(adler_a));

    // start_i re-pulsed in DATA is ignored.
    fill_random(9);
    applyStimulus("repulse", 2, 1, 20, -1, 1, 0);
    checkOutput("repulse");

    // lst_i on the wrong word: framing still follows w*h.
`ifdef ZLIB_STORED_LEN_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    fill_random(5);
    applyStimulus("badlst", 1, 1, 0, -1, 0, 1);
    checkOutput("badlst");
    check_val("badlst_err", 64'(err_o), 64'(exp_err));
    fill_random(5);
    applyStimulus("goodlst", 1, 1, 0, -1, 0, 0);
    checkOutput("goodlst");
    check_val("goodlst_err", 64'(err_o), 64'd0);

    // Randomized streams against the model.
    for (int r = 0; r < 12; r++) begin
      w = $urandom_range(4);
      h = $urandom_range(4);
      sa = ($urandom_range(1) == 1) ? int'($urandom_range(20)) : -1;
      fill_random(h * (4 * w + 1));
      applyStimulus($sformatf("rand%0d", r), w, h, 25, sa, 1'($urandom_range(1)), 0);
      checkOutput($sformatf("rand%0d", r));
    end

    // Reset asserted in DATA aborts at once.
    fill_random(18);
    @(posedge clk); #1;
    w_i = 32'd2; h_i = 32'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!rdy_o && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check_val("abort_reached_data", 64'(rdy_o), 64'd1);
    val_i = 1'b1; dat_i = {src_bytes[0], src_bytes[1], src_bytes[2], src_bytes[3]}; num_i = 2'd3;
    @(posedge clk); #1;
    val_i = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_val("abort_outputs", {25'd0, val_o, dat_o, num_o, lst_o, done_o, rdy_o, err_o}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    fill_random(5);
    applyStimulus("after_abort", 1, 1, 0, -1, 0, 0);
    checkOutput("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
